dsp_mul_arbiter: RTL and testbench

- Shares one DSP48A1 multiplier path between NREQ requesters. Each requester streams operand pairs in bursts.
- Round-robin arbitration happens at burst boundaries. The granted requester's operands are driven into the slice, and a tag pipeline tracks ownership through the slice latency. Each product is returned with the ID of its owner.
- Sits between the filter/MAC clients and the slice instance (B_INPUT="DIRECT", OPMODE[4]=0, so B goes straight to the multiplier).

---
 rtl/dsp_pkg.sv | 20 ++
 rtl/dsp_tag_pipe.sv | 45 ++++
 rtl/dsp_mul_arbiter.sv | 155 +++++++++++++++
 tb/tb_dsp_mul_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared types and constants for the DSP48A1 multiplier arbiter.
package dsp_pkg;

  localparam int unsigned DSP_AW = 18;
  localparam int unsigned DSP_MW = 36;
  localparam int unsigned ID_W   = 2;

  localparam logic [7:0] OPMODE_MUL_DIRECT = 8'h00;

  typedef enum logic [0:0] {
    IDLE,
    GRANT
  } state_e;

  // Cyclic successor of a requester index within n requesters.
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id, input int unsigned n);
    return ID_W'((32'(id) + 32'd1) % n);
  endfunction

endpackage

// File: rtl/dsp_tag_pipe.sv
// Ownership tag shift register that tracks each product through the slice latency.
module dsp_tag_pipe #(
  parameter int unsigned LAT = 2,
  parameter int unsigned IDW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [IDW-1:0] in_id,
  input  logic           in_last,
  output logic           out_valid,
  output logic [IDW-1:0] out_id,
  output logic           out_last,
  output logic           any_valid
);

  logic [LAT-1:0] valid_q;
  logic [LAT-1:0] last_q;
  logic [IDW-1:0] id_q [LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      last_q  <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        id_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      last_q[0]  <= in_last;
      id_q[0]    <= in_id;
      for (int unsigned i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        last_q[i]  <= last_q[i-1];
        id_q[i]    <= id_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[LAT-1];
  assign out_last  = last_q[LAT-1];
  assign out_id    = id_q[LAT-1];
  assign any_valid = |valid_q;

endmodule

// File: rtl/dsp_mul_arbiter.sv
// Burst-granular round-robin sharing of one DSP48A1 multiplier among NREQ requesters,
// returning each product tagged with its owner.
module dsp_mul_arbiter
  import dsp_pkg::*;
#(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned MUL_LAT   = 2,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_last,
  input  logic [NREQ*DSP_AW-1:0] req_a,
  input  logic [NREQ*DSP_AW-1:0] req_b,
  output logic [NREQ-1:0]        req_ready,
  output logic [DSP_AW-1:0]      dsp_a,
  output logic [DSP_AW-1:0]      dsp_b,
  output logic                   dsp_ce,
  output logic [7:0]             dsp_opmode,
  input  logic [DSP_MW-1:0]      dsp_m,
  output logic                   resp_valid,
  output logic [ID_W-1:0]        resp_id,
  output logic                   resp_last,
  output logic [DSP_MW-1:0]      resp_m,
  output logic                   busy
);

  localparam int unsigned CW = $clog2(MAX_BURST);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ID_W-1:0]   pick;
  logic              found;
  logic              sel_valid, sel_last;
  logic [DSP_AW-1:0] sel_a, sel_b;
  logic              accept, forced, burst_end, eff_last;
  logic [ID_W-1:0]   tag_in_id;
  logic              pipe_busy;

  // Granted requester's flags and operands.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_a     = '0;
    sel_b     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_q == ID_W'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_a     = req_a[DSP_AW*i +: DSP_AW];
        sel_b     = req_b[DSP_AW*i +: DSP_AW];
      end
    end
  end

  // First valid requester at or after rr_q, scanning cyclically.
  always_comb begin
    found = 1'b0;
    pick  = rr_q;
    for (int unsigned k = 0; k < NREQ; k++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && req_valid[i] && ((32'(rr_q) + k) % NREQ) == i) begin
          found = 1'b1;
          pick  = ID_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (accept) begin
          if (burst_end) begin
            state_d = IDLE;
            rr_d    = next_id(gnt_q, NREQ);
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready depends only on state and grant, never on valid.
  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    forced    = 1'b0;
    burst_end = 1'b0;
    if (state_q == GRANT) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        req_ready[i] = (gnt_q == ID_W'(i));
      end
      accept    = sel_valid;
      forced    = (cnt_q == CW'(MAX_BURST - 1));
      burst_end = accept && (sel_last || forced);
    end
  end

  assign eff_last   = sel_last | forced;
  assign tag_in_id  = accept ? gnt_q : '0;
  assign dsp_a      = accept ? sel_a : '0;
  assign dsp_b      = accept ? sel_b : '0;
  assign dsp_ce     = 1'b1;
  assign dsp_opmode = OPMODE_MUL_DIRECT;

  dsp_tag_pipe #(
    .LAT(MUL_LAT),
    .IDW(ID_W)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (accept),
    .in_id    (tag_in_id),
    .in_last  (accept & eff_last),
    .out_valid(resp_valid),
    .out_id   (resp_id),
    .out_last (resp_last),
    .any_valid(pipe_busy)
  );

  assign resp_m = resp_valid ? dsp_m : '0;
  assign busy   = (state_q == GRANT) | pipe_busy;

endmodule

// File: tb/tb_dsp_mul_arbiter.sv
// Scoreboard bench for dsp_mul_arbiter with a behavioural slice model and burst-level reference.
module tb_dsp_mul_arbiter;

  localparam int NREQ      = 2;
  localparam int MUL_LAT   = 2;
  localparam int MAX_BURST = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_last = '0;
  logic [NREQ*18-1:0] req_a = '0;
  logic [NREQ*18-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic [17:0]       dsp_a, dsp_b;
  logic              dsp_ce;
  logic [7:0]        dsp_opmode;
  logic [35:0]       dsp_m;
  logic              resp_valid;
  logic [1:0]        resp_id;
  logic              resp_last;
  logic [35:0]       resp_m;
  logic              busy;

  dsp_mul_arbiter #(
    .NREQ(NREQ),
    .MUL_LAT(MUL_LAT),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_ce(dsp_ce), .dsp_opmode(dsp_opmode), .dsp_m(dsp_m),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_last(resp_last), .resp_m(resp_m),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Slice model: A1/B1 registers then MREG.
  logic [17:0] a_r = '0, b_r = '0;
  logic [35:0] m_r = '0;
  always @(posedge clk) begin
    if (dsp_ce) begin
      a_r <= dsp_a;
      b_r <= dsp_b;
      m_r <= 36'(a_r) * 36'(b_r);
    end
  end
  assign dsp_m = m_r;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [17:0] a; logic [17:0] b; logic last; int stall;} beat_t;
  typedef struct {logic [1:0] id; logic last; logic [35:0] m; int cyc;} exp_t;
  typedef struct {int id; int start; int stop; int len;} burst_t;

  beat_t  srcq [NREQ][$];
  exp_t   sb[$];
  burst_t blog[$];
  int     acc_cyc[$];
  int     bcnt[NREQ];
  int     acc_total;
  int     prev_end;
  bit     in_burst;
  logic [35:0] last_m = '0;
  exp_t   mon_e;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic clear_state();
    for (int i = 0; i < NREQ; i++) begin
      srcq[i].delete();
      bcnt[i] = 0;
    end
    sb.delete();
    blog.delete();
    acc_cyc.delete();
    acc_total = 0;
    prev_end  = -100;
    in_burst  = 0;
  endtask

  task automatic push_beat(input int i, input logic [17:0] a, input logic [17:0] b,
                           input logic last, input int stall);
    beat_t h;
    h.a = a; h.b = b; h.last = last; h.stall = stall;
    srcq[i].push_back(h);
  endtask

  // Reference: per-requester beat count decides the effective last; bursts are logged.
  task automatic log_accept(input int i);
    beat_t h;
    burst_t bb;
    logic [35:0] p;
    logic el;
    h = srcq[i].pop_front();
    chk("ready_onehot", 64'($countones(req_ready)), 64'd1);
    chk("dsp_a_mux", dsp_a, h.a);
    chk("dsp_b_mux", dsp_b, h.b);
    bcnt[i]++;
    el = h.last || (bcnt[i] == MAX_BURST);
    if (el) bcnt[i] = 0;
    p = 36'(h.a) * 36'(h.b);
    sb.push_back('{id: 2'(i), last: el, m: p, cyc: cyc});
    acc_total++;
    acc_cyc.push_back(cyc);
    if (!in_burst) begin
      if (blog.size() > 0) chk("dead_cycle", 64'(cyc >= prev_end + 2), 64'd1);
      blog.push_back('{id: i, start: cyc, stop: cyc, len: 1});
      in_burst = 1;
    end else begin
      bb = blog[blog.size()-1];
      chk("burst_owner", 64'(i), 64'(bb.id));
      bb.stop = cyc;
      bb.len++;
      blog[blog.size()-1] = bb;
    end
    if (el) begin
      in_burst = 0;
      prev_end = cyc;
    end
  endtask

  // Driver: present head-of-queue beats, garbage operands when idle.
  always @(negedge clk) begin : drv
    beat_t h;
    bit any_acc;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]        = 1'b0;
      req_last[i]         = 1'($urandom);
      req_a[18*i +: 18]   = 18'($urandom);
      req_b[18*i +: 18]   = 18'($urandom);
      if (!rst && srcq[i].size() > 0) begin
        h = srcq[i][0];
        if (h.stall > 0) begin
          h.stall--;
          srcq[i][0] = h;
        end else begin
          req_valid[i]      = 1'b1;
          req_last[i]       = h.last;
          req_a[18*i +: 18] = h.a;
          req_b[18*i +: 18] = h.b;
        end
      end
    end
    #1;
    any_acc = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        any_acc = 1;
        log_accept(i);
      end
    end
    if (!any_acc) chk("dsp_ab_idle", {dsp_a, dsp_b}, 36'd0);
  end

  // Monitor: pop the scoreboard whenever a product is presented.
  always @(negedge clk) begin : mon
    if (!rst) begin
      if (resp_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_resp: actual resp_valid=1 id=%0d m=%0h, required no response",
                   resp_id, resp_m);
        end else begin
          mon_e = sb.pop_front();
          chk("resp_id", resp_id, mon_e.id);
          chk("resp_last", resp_last, mon_e.last);
          chk("resp_m", resp_m, mon_e.m);
          chk("resp_latency", 64'(cyc - mon_e.cyc), 64'(MUL_LAT));
          last_m = resp_m;
        end
      end else begin
        chk("resp_idle", {resp_id, resp_last, resp_m}, 39'd0);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_state();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    int pend;
    pend = sb.size();
    for (int i = 0; i < NREQ; i++) pend += srcq[i].size();
    while (pend != 0 && t < 3000) begin
      @(negedge clk);
      t++;
      pend = sb.size();
      for (int i = 0; i < NREQ; i++) pend += srcq[i].size();
    end
    if (t >= 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: actual %0d items pending, required 0", name, pend);
    end
    repeat (3) @(negedge clk);
    #2;
    chk({name, "_busy_after"}, busy, 1'b0);
    chk({name, "_resp_after"}, resp_valid, 1'b0);
  endtask

  task automatic chk_bursts(input string name, input int n, input int ids[4], input int lens[4]);
    chk({name, "_nbursts"}, 64'(blog.size()), 64'(n));
    for (int k = 0; k < n && k < blog.size(); k++) begin
      chk({name, "_burst_id"}, 64'(blog[k].id), 64'(ids[k]));
      chk({name, "_burst_len"}, 64'(blog[k].len), 64'(lens[k]));
    end
  endtask

  initial begin
    int t;
    int total;
    int len;
    clear_state();

    // Reset values while reset is held.
    #3;
    chk("rst_ready", req_ready, '0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_id", resp_id, 2'd0);
    chk("rst_resp_last", resp_last, 1'b0);
    chk("rst_resp_m", resp_m, 36'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dsp_ce", dsp_ce, 1'b1);
    chk("rst_opmode", dsp_opmode, 8'h00);
    chk("rst_dsp_a", dsp_a, 18'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // Single requester, 3-beat burst.
    push_beat(0, 18'd2, 18'd3, 1'b0, 0);
    push_beat(0, 18'd5, 18'd7, 1'b0, 0);
    push_beat(0, 18'd0, 18'h3FFFF, 1'b1, 0);
    drain("single");
    chk_bursts("single", 1, '{0, 0, 0, 0}, '{3, 0, 0, 0});
    if (blog.size() == 1) chk("single_consecutive", 64'(blog[0].stop - blog[0].start), 64'd2);

    // Contention from reset: strict alternation with one dead cycle.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        push_beat(i, 18'(10 * i + k + 1), 18'(k + 2), 1'b0, 0);
        push_beat(i, 18'(10 * i + k + 3), 18'(k + 5), 1'b1, 0);
      end
    end
    drain("contend");
    chk_bursts("contend", 4, '{0, 1, 0, 1}, '{2, 2, 2, 2});
    for (int k = 1; k < 4 && k < blog.size(); k++) begin
      chk("contend_gap", 64'(blog[k].start - blog[k-1].stop), 64'd2);
    end

    // Forced release at MAX_BURST with requester 0 waiting.
    do_reset();
    for (int k = 0; k < 20; k++) push_beat(1, 18'(k + 1), 18'(k + 100), 1'(k == 19), 0);
    t = 0;
    while (blog.size() == 0 && t < 100) begin
      @(negedge clk);
      #2;
      t++;
    end
    chk("forced_started", 64'(blog.size() > 0), 64'd1);
    push_beat(0, 18'd9, 18'd9, 1'b0, 0);
    push_beat(0, 18'd8, 18'd8, 1'b1, 0);
    drain("forced");
    chk_bursts("forced", 3, '{1, 0, 1, 0}, '{16, 2, 4, 0});

    // Max operands.
    do_reset();
    push_beat(1, 18'h3FFFF, 18'h3FFFF, 1'b1, 0);
    drain("maxop");
    chk("max_product", last_m, 36'hFFFF80001);

    // Requester 0 stalls 3 cycles mid-burst; requester 1 must wait.
    do_reset();
    for (int k = 0; k < 5; k++) push_beat(0, 18'(k + 20), 18'(k + 30), 1'(k == 4), (k == 3) ? 3 : 0);
    push_beat(1, 18'd11, 18'd12, 1'b0, 0);
    push_beat(1, 18'd13, 18'd14, 1'b1, 0);
    drain("stall");
    chk_bursts("stall", 2, '{0, 1, 0, 0}, '{5, 2, 0, 0});
    if (acc_cyc.size() >= 4) begin
      chk("stall_gap", 64'(acc_cyc[3] - acc_cyc[2]), 64'd4);
      chk("stall_nogap", 64'(acc_cyc[1] - acc_cyc[0]), 64'd1);
    end

    // Asynchronous reset with two beats in flight.
    do_reset();
    for (int k = 0; k < 4; k++) push_beat(0, 18'(k + 3), 18'(k + 4), 1'(k == 3), 0);
    t = 0;
    while (acc_total < 2 && t < 100) begin
      @(negedge clk);
      #2;
      t++;
    end
    chk("arst_two_accepted", 64'(acc_total >= 2), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_resp_valid", resp_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_ready", req_ready, '0);
    clear_state();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #2;
      chk("arst_quiet", {resp_valid, busy}, 2'b00);
    end
    push_beat(1, 18'd6, 18'd6, 1'b1, 0);
    push_beat(0, 18'd7, 18'd7, 1'b1, 0);
    drain("arst_after");
    chk_bursts("arst_after", 2, '{0, 1, 0, 0}, '{1, 1, 0, 0});

    // Randomised bursts with random stalls on all requesters.
    do_reset();
    total = 0;
    for (int i = 0; i < NREQ; i++) begin
      for (int b = 0; b < 8; b++) begin
        len = int'($urandom_range(1, 20));
        for (int k = 0; k < len; k++) begin
          push_beat(i, 18'($urandom), 18'($urandom), 1'(k == len - 1),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end
        total += len;
      end
    end
    drain("random");
    chk("random_beats", 64'(acc_total), 64'(total));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
